// File: rtl/instruction_loader.sv
// Boot-time program loader: receives a byte stream (word count, big-endian words,
// XOR checksum) and writes each packed word into instruction memory.
module instruction_loader #(
  parameter int unsigned BASE_ADDR = 400,
  parameter int unsigned ADDR_STEP = 4,
  parameter int unsigned MAX_WORDS = 28
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        start,
  input  logic [7:0]  byteIn,
  input  logic        byteValid,
  output logic        byteReady,
  output logic        InsMemRW,
  output logic        wEn,
  output logic [31:0] wAddr,
  output logic [31:0] wData,
  output logic [5:0]  wordCount,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [31:0] BASE_W = 32'(BASE_ADDR);
  localparam logic [31:0] STEP_W = 32'(ADDR_STEP);
  localparam logic [7:0]  MAX_B  = 8'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  n_q, n_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  csum_q, csum_d;
  logic [23:0] word_q, word_d;
  logic        wen_q, wen_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [5:0]  wcount_q, wcount_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        accept_s;

  assign byteReady = (state_q == S_HEADER) || (state_q == S_DATA) || (state_q == S_CHECK);
  assign InsMemRW  = byteReady || (state_q == S_WRITE);
  assign accept_s  = byteValid && byteReady;

  assign wEn       = wen_q;
  assign wAddr     = waddr_q;
  assign wData     = wdata_q;
  assign wordCount = wcount_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

  // State and datapath registers
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      n_q      <= 6'd0;
      cnt_q    <= 2'd0;
      csum_q   <= 8'd0;
      word_q   <= 24'd0;
      wen_q    <= 1'b0;
      waddr_q  <= BASE_W;
      wdata_q  <= 32'd0;
      wcount_q <= 6'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      csum_q   <= csum_d;
      word_q   <= word_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wcount_q <= wcount_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    csum_d   = csum_q;
    word_d   = word_q;
    wen_d    = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    wcount_d = wcount_q;
    done_d   = done_q;
    error_d  = error_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d  = S_HEADER;
          done_d   = 1'b0;
          error_d  = 1'b0;
          wcount_d = 6'd0;
          cnt_d    = 2'd0;
          csum_d   = 8'd0;
          waddr_d  = BASE_W;
        end else begin
          state_d = state_q;
        end
      end
      S_HEADER: begin
        if (!accept_s) begin
          state_d = S_HEADER;
        end else if ((byteIn == 8'd0) || (byteIn > MAX_B)) begin
          state_d = S_ERROR;
          error_d = 1'b1;
        end else begin
          n_d     = byteIn[5:0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept_s) begin
          word_d = {word_q[15:0], byteIn};
          csum_d = csum_q ^ byteIn;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_WRITE;
            wen_d   = 1'b1;
            wdata_d = {word_q, byteIn};
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_WRITE: begin
        // address and count advance only after the memory has captured the word
        waddr_d  = waddr_q + STEP_W;
        wcount_d = wcount_q + 6'd1;
        if ((wcount_q + 6'd1) == n_q) begin
          state_d = S_CHECK;
        end else begin
          state_d = S_DATA;
        end
      end
      S_CHECK: begin
        if (!accept_s) begin
          state_d = S_CHECK;
        end else if (byteIn == csum_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_ERROR;
          error_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_HEADER) || (state_d == S_DATA) ||
             (state_d == S_WRITE)  || (state_d == S_CHECK);
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: a stream-level model predicts every memory write
// and the final flags; a negedge monitor checks each wEn pulse against it.
module tb_instruction_loader;

  logic        CLK, Reset, start, byteValid;
  logic [7:0]  byteIn;
  logic        byteReady, InsMemRW, wEn, busy, done, error;
  logic [31:0] wAddr, wData;
  logic [5:0]  wordCount;

  instruction_loader dut (
    .CLK(CLK), .Reset(Reset), .start(start), .byteIn(byteIn), .byteValid(byteValid),
    .byteReady(byteReady), .InsMemRW(InsMemRW), .wEn(wEn), .wAddr(wAddr), .wData(wData),
    .wordCount(wordCount), .busy(busy), .done(done), .error(error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_pass  = 0;
  int n_wen   = 0;
  logic [63:0] exp_q [$];
  logic [31:0] prog [$];
  logic [31:0] last_waddr, last_wdata;
  logic [7:0]  last_cs;
  logic        prev_wen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Every write strobe must match the next predicted (address, word) pair.
  always @(negedge CLK) begin
    if (wEn) begin
      n_wen++;
      chk("wen_single_cycle", {31'd0, prev_wen}, 32'd0);
      chk("ready_low_in_write", {31'd0, byteReady}, 32'd0);
      chk("insmemrw_in_write", {31'd0, InsMemRW}, 32'd1);
      chk("wen_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("wAddr", wAddr, e[63:32]);
        chk("wData", wData, e[31:0]);
      end
      last_waddr = wAddr;
      last_wdata = wData;
    end
    prev_wen = wEn;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_values();
    chk("rst_wEn", {31'd0, wEn}, 32'd0);
    chk("rst_InsMemRW", {31'd0, InsMemRW}, 32'd0);
    chk("rst_byteReady", {31'd0, byteReady}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_wAddr", wAddr, 32'd400);
    chk("rst_wData", wData, 32'd0);
    chk("rst_wordCount", {26'd0, wordCount}, 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    byteIn    = b;
    byteValid = 1'b1;
    t = 0;
    while (!byteReady && t < 20) begin
      tick();
      t++;
    end
    if (t >= 20) chk("byteReady_timeout", {31'd0, byteReady}, 32'd1);
    tick();
    byteValid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_done_clr", {31'd0, done}, 32'd0);
    chk("start_error_clr", {31'd0, error}, 32'd0);
    chk("start_wordCount_clr", {26'd0, wordCount}, 32'd0);
    chk("start_wAddr_base", wAddr, 32'd400);
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_InsMemRW", {31'd0, InsMemRW}, 32'd1);
  endtask

  // Streams prog[] as one load; stall idles between data bytes, mid_start pulses start on that data byte.
  task automatic run_load(input int stall, input int mid_start, input logic force_tr, input logic [7:0] tr);
    logic [7:0] cs, b;
    logic good;
    cs = 8'h00;
    do_start();
    send_byte(8'(prog.size()));
    for (int w = 0; w < prog.size(); w++) begin
      exp_q.push_back({32'(400 + 4 * w), prog[w]});
      for (int k = 0; k < 4; k++) begin
        b = prog[w][31 - 8 * k -: 8];
        cs = cs ^ b;
        if (w * 4 + k == mid_start) start = 1'b1;
        send_byte(b);
        start = 1'b0;
        repeat (stall) tick();
      end
    end
    last_cs = cs;
    good = !force_tr || (tr == cs);
    send_byte(force_tr ? tr : cs);
    chk("end_done", {31'd0, done}, {31'd0, good});
    chk("end_error", {31'd0, error}, {31'd0, !good});
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("end_InsMemRW", {31'd0, InsMemRW}, 32'd0);
    chk("end_wordCount", {26'd0, wordCount}, 32'(prog.size()));
    chk("end_all_writes_seen", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic bad_header(input logic [7:0] n);
    int w0;
    w0 = n_wen;
    do_start();
    send_byte(n);
    chk("badhdr_error", {31'd0, error}, 32'd1);
    chk("badhdr_done", {31'd0, done}, 32'd0);
    chk("badhdr_busy", {31'd0, busy}, 32'd0);
    byteIn    = 8'h01;
    byteValid = 1'b1;
    repeat (3) begin
      tick();
      chk("badhdr_not_ready", {31'd0, byteReady}, 32'd0);
    end
    byteValid = 1'b0;
    chk("badhdr_no_wen", 32'(n_wen - w0), 32'd0);
    chk("badhdr_error_held", {31'd0, error}, 32'd1);
  endtask

  initial begin
    Reset = 1'b0; start = 1'b0; byteValid = 1'b0; byteIn = 8'h00;
    repeat (2) tick();
    check_reset_values();
    Reset = 1'b1;
    tick();
    check_reset_values();

    // Full 12-word program load
    prog = '{32'h04010007, 32'h04020003, 32'h00221800, 32'h24430001,
             32'h10000002, 32'h08640005, 32'hC0A10004, 32'hC4A20008,
             32'h1C60FFFF, 32'h4C22000A, 32'hE0000004, 32'hFC000000};
    run_load(0, -1, 1'b0, 8'h00);
    chk("full_last_waddr", last_waddr, 32'd444);
    chk("full_last_wdata", last_wdata, 32'hFC000000);
    chk("full_wAddr_after", wAddr, 32'd448);

    // Stalled single word
    prog = '{32'hDEADBEEF};
    run_load(3, -1, 1'b0, 8'h00);
    chk("stall_model_csum", {24'd0, last_cs}, 32'h22);
    chk("stall_waddr", last_waddr, 32'd400);
    chk("stall_wdata", last_wdata, 32'hDEADBEEF);

    bad_header(8'd0);
    bad_header(8'd29);

    // Checksum mismatch
    prog = '{32'h00000001};
    run_load(0, -1, 1'b1, 8'h00);
    chk("csum_waddr", last_waddr, 32'd400);
    chk("csum_wdata", last_wdata, 32'h00000001);

    // Largest legal program
    prog.delete();
    for (int i = 0; i < 28; i++) prog.push_back(32'h01010101 * 32'(i + 1) ^ 32'h5A000000);
    run_load(0, -1, 1'b0, 8'h00);
    chk("max_last_waddr", last_waddr, 32'd508);
    chk("max_wAddr_after", wAddr, 32'd512);

    // Reset after the 2nd byte of word 3
    do_start();
    send_byte(8'd5);
    exp_q.push_back({32'd400, 32'h11223344});
    exp_q.push_back({32'd404, 32'h55667788});
    for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i) * 8'h11);
    for (int i = 0; i < 4; i++) send_byte(8'h55 + 8'(i) * 8'h11);
    send_byte(8'h99);
    send_byte(8'hAA);
    chk("abort_two_writes", 32'(exp_q.size()), 32'd0);
    Reset = 1'b0;
    #1;
    check_reset_values();
    repeat (3) tick();
    Reset = 1'b1;
    tick();
    check_reset_values();
    prog = '{32'hCAFEF00D, 32'h0BADC0DE};
    run_load(0, -1, 1'b0, 8'h00);
    chk("reload_last_waddr", last_waddr, 32'd404);

    // start during DATA is ignored; a later start reloads from the base
    prog = '{32'h01020304, 32'hA0B0C0D0, 32'h7F7F7F7F};
    run_load(0, 5, 1'b0, 8'h00);
    prog = '{32'h31415926, 32'h27182818};
    run_load(0, -1, 1'b0, 8'h00);
    chk("restart_last_wdata", last_wdata, 32'h27182818);
    chk("restart_last_waddr", last_waddr, 32'd404);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Boot-time program loader that fills instruction memory before the single-cycle CPU runs. It accepts a byte stream over a valid/ready handshake: a word-count header, then 4 bytes per instruction, big-endian, then an XOR checksum byte. It packs each group of 4 bytes into a 32-bit instruction word and issues one write per word at consecutive word addresses starting at the program base. It is the write-side counterpart of the instruction memory's read port: it drives `InsMemRW`, the write address and the write data.

## Interface
- `BASE_ADDR`, 400: byte address of the first instruction written.
- `ADDR_STEP`, 4: address increment per word.
- `MAX_WORDS`, 28: largest legal word count (addresses 400..508).
- `CLK` input 1: clock; all state changes on the rising edge.
- `Reset` input 1: asynchronous, active-low reset.
- `start` input 1: begin a load. Sampled in IDLE, DONE and ERROR; ignored in any other state.
- `byteIn` input 8: stream byte.
- `byteValid` input 1: `byteIn` is valid.
- `byteReady` output 1: loader can accept a byte. A byte transfers on an edge where `byteValid` and `byteReady` are both 1.
- `InsMemRW` output 1: 1 = memory in write mode (load in progress); 0 = read mode.
- `wEn` output 1: one-cycle write strobe for `wAddr`/`wData`.
- `wAddr` output 32: instruction memory write address.
- `wData` output 32: instruction word to write.
- `wordCount` output 6: number of words written in the current load.
- `busy` output 1: a load is in progress (any state other than IDLE, DONE and ERROR).
- `done` output 1: last load completed with a good checksum. Held until the next `start` or reset.
- `error` output 1: last load failed on a bad header or a checksum mismatch. Held until the next `start` or reset.

## Operation
- **States:** IDLE, HEADER, DATA, WRITE, CHECK, DONE, ERROR.
- **Start:**
  - IDLE/DONE/ERROR with `start`=1 → HEADER.
  - On this transition: clear `done`, `error`, `wordCount`, the byte counter and the checksum; set `wAddr`=`BASE_ADDR`.
- **HEADER:** accept 1 byte as N.
  - N=0 or N>`MAX_WORDS` → ERROR, with no data bytes consumed.
  - Otherwise → DATA.
- **DATA:** accept bytes.
  - Shift each byte into the word register from the MSB side: the first byte becomes bits 31:24.
  - XOR each byte into the 8-bit checksum.
  - When the 4th byte is accepted → WRITE.
- **WRITE:** a single cycle.
  - `wEn`=1, `wData`=the packed word, `wAddr`=current address.
  - At the end of the cycle: `wAddr`+=`ADDR_STEP` and `wordCount`+=1.
  - → CHECK if `wordCount`+1==N, else → DATA.
- **CHECK:** accept 1 byte.
  - Equal to the running checksum → DONE.
  - Otherwise → ERROR.
  - Words already written are not undone.
- **DONE/ERROR:** idle with the flag held. `start` begins a new load.
- **`InsMemRW`:** 1 in HEADER, DATA, WRITE and CHECK; 0 in IDLE, DONE and ERROR.
- **`byteReady`:** 1 in HEADER, DATA and CHECK only. Bytes presented in other states are not consumed.
- **Arithmetic:**
  - `wAddr` is a 32-bit unsigned add; wrap-around cannot occur within the legal N range.
  - The checksum covers data bytes only, not the header.

## Timing
- All outputs are registered except `byteReady` and `InsMemRW`, which are decoded from the state register.
- **Reset values:**
  - State: IDLE.
  - `wEn`, `InsMemRW`, `byteReady`, `busy`, `done`, `error`: 0.
  - `wAddr`: `BASE_ADDR`.
  - `wData`: 0.
  - `wordCount`: 0.
- **Write latency:** the 4th byte of a word is accepted on edge k. `wEn`, `wData` and `wAddr` are valid from edge k until edge k+1; the memory captures on edge k+1.
- **Throughput:** at most 4 bytes per 5 cycles, because WRITE inserts one cycle with `byteReady`=0.
- **Stalls:** `byteValid`=0 causes the FSM to hold its state and all counters, for any duration.
- **`done`/`error` timing:** each rises on the edge after the CHECK or HEADER byte is accepted.
- **`start` coinciding with a byte:** in IDLE, DONE or ERROR, `start`=1 together with `byteValid`=1 in the same cycle does not consume the byte, because `byteReady`=0 in those states.
- **Reset mid-load:** any state returns to IDLE immediately. No further `wEn` pulses are issued. Memory contents are left as they are.

## Test plan
- **Full program load:**
  - Stimulus: `start`, N=12, then the 12-word program. Words include 0x04010007 first and 0xFC000000 last; the correct XOR trailer follows.
  - Required: 12 `wEn` pulses at `wAddr` 400, 404, …, 444 with the matching `wData`; `wordCount`=12; `done`=1; `error`=0; `InsMemRW` returns to 0.
- **Stall handling:**
  - Stimulus: N=1, bytes 0xDE 0xAD 0xBE 0xEF with `byteValid` dropped for 3 cycles between each byte; checksum 0x22.
  - Required: a single `wEn` with `wData`=0xDEADBEEF at `wAddr`=400; `done`=1.
- **Bad header:**
  - Stimulus: N=0, then separately N=29.
  - Required: `error`=1 one edge after the header; no `wEn` pulse; the next byte is not accepted.
- **Checksum mismatch:**
  - Stimulus: N=1, bytes 0x00 0x00 0x00 0x01, trailer 0x00.
  - Required: one write of 0x00000001 at 400; `error`=1; `done`=0.
- **Reset mid-load:**
  - Stimulus: assert `Reset`=0 after the 2nd data byte of word 3, then release it and perform a new full load.
  - Required: all outputs at their reset values; no 3rd write from the aborted load; the new load starts at `wAddr`=400.
- **Restart and ignored `start`:**
  - Stimulus: assert `start` during DATA; after `done`, assert `start` again.
  - Required: the mid-load `start` has no effect; the second load clears `done` and `wordCount` and rewrites from address 400.
